// File: rtl/multi_key_debounce.sv
// multi_key_debounce: N-channel push-button debouncer.
// Each channel has a 2-flop synchroniser, a four-state filter FSM and a
// stability counter. It produces a registered debounced level plus one-cycle
// press and release pulses.
// Optional feature macro: KEY_LONG_PRESS_EN adds a per-channel long-press
// counter and a one-cycle key_long pulse. Without it, key_long is tied to 0.
module multi_key_debounce #(
    parameter int KEY_NUM   = 4,
    parameter int TIME_20MS = 1_000_000,
    parameter int LONG_TIME = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_down,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FILTER_DN = 2'd1,
        S_DOWN      = 2'd2,
        S_FILTER_UP = 2'd3
    } state_t;

    localparam int            CW      = (TIME_20MS > 1) ? $clog2(TIME_20MS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIME_20MS - 1);

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        state_t        r_state;
        state_t        w_next;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_next;
        logic          w_press;
        logic          w_release;
        logic          w_down_next;
        logic          r_down;
        logic          r_press;
        logic          r_release;

        // Two-flop synchroniser; pins idle high (released).
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
            end else begin
                r_s1 <= key_in[g];
                r_s2 <= r_s1;
            end
        end

        // State, stability counter and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_down    <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_next;
                r_cnt     <= w_cnt_next;
                r_down    <= w_down_next;
                r_press   <= w_press;
                r_release <= w_release;
            end
        end

        // Next-state, counter update and pulse requests.
        always_comb begin
            w_next      = r_state;
            w_cnt_next  = r_cnt;
            w_press     = 1'b0;
            w_release   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_s2) begin
                        w_next     = S_FILTER_DN;
                        w_cnt_next = '0;
                    end
                end
                S_FILTER_DN: begin
                    if (r_s2) begin
                        w_next     = S_IDLE;
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_next     = S_DOWN;
                        w_cnt_next = '0;
                        w_press    = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (r_s2) begin
                        w_next     = S_FILTER_UP;
                        w_cnt_next = '0;
                    end
                end
                S_FILTER_UP: begin
                    if (!r_s2) begin
                        w_next     = S_DOWN;
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_next     = S_IDLE;
                        w_cnt_next = '0;
                        w_release  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end
            endcase
            // Level tracks the next state so it moves in the same cycle as the pulses.
            w_down_next = (w_next == S_DOWN) || (w_next == S_FILTER_UP);
        end

        assign key_down[g]    = r_down;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;

`ifdef KEY_LONG_PRESS_EN
        localparam int            LW       = (LONG_TIME > 1) ? $clog2(LONG_TIME) : 1;
        localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TIME - 1);

        logic [LW-1:0] r_lcnt;
        logic          r_fired;
        logic          r_long;

        // Long-press counter: restarts on a fresh press, saturates, fires once.
        // Suppressed on the release edge so it never coincides with key_release.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_lcnt  <= '0;
                r_fired <= 1'b0;
                r_long  <= 1'b0;
            end else if (r_state == S_FILTER_DN && w_next == S_DOWN) begin
                r_lcnt  <= '0;
                r_fired <= 1'b0;
                r_long  <= 1'b0;
            end else if (r_state == S_DOWN || r_state == S_FILTER_UP) begin
                r_long <= 1'b0;
                if (r_lcnt != LONG_MAX) begin
                    r_lcnt <= r_lcnt + 1'b1;
                end else if (!r_fired && w_next != S_IDLE) begin
                    r_long  <= 1'b1;
                    r_fired <= 1'b1;
                end
            end else begin
                r_lcnt  <= '0;
                r_fired <= 1'b0;
                r_long  <= 1'b0;
            end
        end

        assign key_long[g] = r_long;
`else
        assign key_long[g] = 1'b0;
`endif
    end

endmodule
